// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit write engine.
package lcd_pkg;

    // Default timing in SYS_CLK_50M cycles.
    localparam int unsigned T_PWR_DEF  = 750000;
    localparam int unsigned T_AS_DEF   = 2;
    localparam int unsigned T_EH_DEF   = 12;
    localparam int unsigned T_NIB_DEF  = 50;
    localparam int unsigned T_CMD_DEF  = 2000;
    localparam int unsigned T_LONG_DEF = 82000;
    localparam int unsigned CNT_W_DEF  = 20;

    // Instructions that need the long execution wait.
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        H_SET,
        H_PUL,
        GAP,
        L_SET,
        L_PUL,
        WAIT
    } lcd_state_e;

    // Byte latched at the accept handshake.
    typedef struct packed {
        logic       rs;
        logic       nib_only;
        logic [7:0] data;
    } lcd_byte_t;

    // Clear display and return home take far longer than other instructions.
    function automatic logic is_long_cmd(input lcd_byte_t b);
        return (!b.rs) && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit write engine: one byte per handshake, timing from cycle counters.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR  = T_PWR_DEF,
    parameter int unsigned T_AS   = T_AS_DEF,
    parameter int unsigned T_EH   = T_EH_DEF,
    parameter int unsigned T_NIB  = T_NIB_DEF,
    parameter int unsigned T_CMD  = T_CMD_DEF,
    parameter int unsigned T_LONG = T_LONG_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic       SYS_CLK_50M,
    input  logic       SYS_RST_N,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    input  logic       in_nib_only,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [3:0] LCD_DATA
);

    // Counter load value for a phase lasting n cycles (n >= 1).
    function automatic logic [CNT_W-1:0] ld(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lcd_byte_t        byte_q, byte_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [3:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             cnt_zero;
    logic [CNT_W-1:0] wait_ld;

    assign cnt_zero = (cnt_q == '0);
    assign wait_ld  = is_long_cmd(byte_q) ? ld(T_LONG) : ld(T_CMD);

    // State register and registered outputs; reset drops E immediately.
    always_ff @(posedge SYS_CLK_50M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= PWRUP;
            cnt_q   <= ld(T_PWR);
            byte_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 4'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; each phase ends when the counter hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        byte_d  = byte_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = 1'b0;

        case (state_q)
            PWRUP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (in_valid && ready_q) begin
                    byte_d  = '{rs: in_rs, nib_only: in_nib_only, data: in_data};
                    rs_d    = in_rs;
                    data_d  = in_data[7:4];
                    state_d = H_SET;
                    cnt_d   = ld(T_AS);
                    ready_d = 1'b0;
                end
            end
            H_SET: begin
                if (cnt_zero) begin
                    state_d = H_PUL;
                    e_d     = 1'b1;
                    cnt_d   = ld(T_EH);
                end
            end
            H_PUL: begin
                if (cnt_zero) begin
                    e_d = 1'b0;
                    if (byte_q.nib_only) begin
                        state_d = WAIT;
                        cnt_d   = wait_ld;
                    end else begin
                        state_d = GAP;
                        cnt_d   = ld(T_NIB);
                    end
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    data_d  = byte_q.data[3:0];
                    state_d = L_SET;
                    cnt_d   = ld(T_AS);
                end
            end
            L_SET: begin
                if (cnt_zero) begin
                    state_d = L_PUL;
                    e_d     = 1'b1;
                    cnt_d   = ld(T_EH);
                end
            end
            L_PUL: begin
                if (cnt_zero) begin
                    e_d     = 1'b0;
                    state_d = WAIT;
                    cnt_d   = wait_ld;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = ld(T_PWR);
                e_d     = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_E    = e_q;
    assign LCD_DATA = data_q;

endmodule
